// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after execute. Passes ALU results straight
// through to write-back and runs LW/SW against a req/ack data memory,
// stalling upstream while an access is outstanding.
// Optional feature: define MS_TIMEOUT_EN to abandon an access that gets no
// ack within TIMEOUT_CYCLES request cycles and flag it on ms_o_mem_err.
module memory_stage #(
  parameter int DWIDTH         = 32,
  parameter int OPCODE_WIDTH   = 6,
  parameter int REG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    ms_i_clk,
  input  logic                    ms_i_rst_n,
  input  logic                    ms_i_ce,
  input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [DWIDTH-1:0]       ms_i_alu_value,
  input  logic [DWIDTH-1:0]       ms_i_data_rt,
  input  logic [REG_WIDTH-1:0]    ms_i_rd_addr,
  input  logic                    ms_i_reg_write,
  input  logic                    ms_i_mem_ack,
  input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
  output logic                    ms_o_mem_req,
  output logic                    ms_o_mem_we,
  output logic [DWIDTH-1:0]       ms_o_mem_addr,
  output logic [DWIDTH-1:0]       ms_o_mem_wdata,
  output logic                    ms_o_stall,
  output logic                    ms_o_ce,
  output logic [DWIDTH-1:0]       ms_o_wb_data,
  output logic [REG_WIDTH-1:0]    ms_o_rd_addr,
  output logic                    ms_o_reg_write,
  output logic                    ms_o_mem_err
);

  localparam logic [OPCODE_WIDTH-1:0] OP_LW = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW = OPCODE_WIDTH'(6'h2B);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [REG_WIDTH-1:0]   lat_rd;
  logic                   lat_rw;
  logic                   is_mem_op;

  assign is_mem_op  = (ms_i_opcode == OP_LW) || (ms_i_opcode == OP_SW);
  assign ms_o_stall = (state == BUSY);

`ifdef MS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] req_cnt;
  logic             err_q;

  assign ms_o_mem_err = err_q;
`else
  assign ms_o_mem_err = 1'b0;
`endif

  // Stage FSM: accept from execute in IDLE, hold the memory handshake in BUSY.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values; blocking would create ordering races.
  always_ff @(posedge ms_i_clk or negedge ms_i_rst_n) begin
    if (!ms_i_rst_n) begin
      state          <= IDLE;
      lat_rd         <= '0;
      lat_rw         <= 1'b0;
      ms_o_mem_req   <= 1'b0;
      ms_o_mem_we    <= 1'b0;
      ms_o_mem_addr  <= '0;
      ms_o_mem_wdata <= '0;
      ms_o_ce        <= 1'b0;
      ms_o_wb_data   <= '0;
      ms_o_rd_addr   <= '0;
      ms_o_reg_write <= 1'b0;
`ifdef MS_TIMEOUT_EN
      req_cnt        <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      // Default: result-valid and error are single-cycle pulses.
      ms_o_ce <= 1'b0;
`ifdef MS_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (ms_i_ce) begin
            if (is_mem_op) begin
              state          <= BUSY;
              ms_o_mem_req   <= 1'b1;
              ms_o_mem_we    <= (ms_i_opcode == OP_SW);
              ms_o_mem_addr  <= {ms_i_alu_value[DWIDTH-1:2], 2'b00};
              ms_o_mem_wdata <= ms_i_data_rt;
              lat_rd         <= ms_i_rd_addr;
              lat_rw         <= ms_i_reg_write;
`ifdef MS_TIMEOUT_EN
              req_cnt        <= '0;
`endif
            end else begin
              ms_o_ce        <= 1'b1;
              ms_o_wb_data   <= ms_i_alu_value;
              ms_o_rd_addr   <= ms_i_rd_addr;
              ms_o_reg_write <= ms_i_reg_write;
            end
          end
        end
        BUSY: begin
          if (ms_i_mem_ack) begin
            // Ack takes priority over a timeout expiring on the same edge.
            state          <= IDLE;
            ms_o_mem_req   <= 1'b0;
            ms_o_ce        <= 1'b1;
            ms_o_rd_addr   <= lat_rd;
            ms_o_wb_data   <= ms_o_mem_we ? '0 : ms_i_mem_rdata;
            ms_o_reg_write <= ms_o_mem_we ? 1'b0 : lat_rw;
          end
`ifdef MS_TIMEOUT_EN
          else if (req_cnt == CNT_LAST) begin
            // Abandon the access; retire it as a non-writing error result.
            state          <= IDLE;
            ms_o_mem_req   <= 1'b0;
            ms_o_ce        <= 1'b1;
            ms_o_rd_addr   <= lat_rd;
            ms_o_wb_data   <= '0;
            ms_o_reg_write <= 1'b0;
            err_q          <= 1'b1;
          end else begin
            req_cnt <= req_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: ALU pass-through, LW/SW handshakes,
// stall hold-off of a following instruction, async reset mid-access, and
// (when MS_TIMEOUT_EN is defined) the access timeout.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [5:0]  opcode;
  logic [31:0] alu_value;
  logic [31:0] data_rt;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        o_ce;
  logic [31:0] wb_data;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write;
  logic        mem_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .ms_i_clk       (clk),
    .ms_i_rst_n     (rst_n),
    .ms_i_ce        (ce),
    .ms_i_opcode    (opcode),
    .ms_i_alu_value (alu_value),
    .ms_i_data_rt   (data_rt),
    .ms_i_rd_addr   (rd_addr),
    .ms_i_reg_write (reg_write),
    .ms_i_mem_ack   (mem_ack),
    .ms_i_mem_rdata (mem_rdata),
    .ms_o_mem_req   (mem_req),
    .ms_o_mem_we    (mem_we),
    .ms_o_mem_addr  (mem_addr),
    .ms_o_mem_wdata (mem_wdata),
    .ms_o_stall     (stall),
    .ms_o_ce        (o_ce),
    .ms_o_wb_data   (wb_data),
    .ms_o_rd_addr   (o_rd_addr),
    .ms_o_reg_write (o_reg_write),
    .ms_o_mem_err   (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge where outputs are sampled
  // and inputs are changed.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] rd, input logic rw);
    ce = c; opcode = op; alu_value = alu; data_rt = rt; rd_addr = rd; reg_write = rw;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("rst_req",   {31'b0, mem_req},     32'h0);
    check("rst_ce",    {31'b0, o_ce},        32'h0);
    check("rst_stall", {31'b0, stall},       32'h0);
    check("rst_wb",    wb_data,              32'h0);
    check("rst_rw",    {31'b0, o_reg_write}, 32'h0);
    check("rst_err",   {31'b0, mem_err},     32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ALU op, latency 1
    drive(1'b1, 6'h00, 32'h1234, 32'h0, 5'd9, 1'b1);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    check("alu_ce",    {31'b0, o_ce},        32'h1);
    check("alu_wb",    wb_data,              32'h1234);
    check("alu_rd",    {27'b0, o_rd_addr},   32'd9);
    check("alu_rw",    {31'b0, o_reg_write}, 32'h1);
    check("alu_stall", {31'b0, stall},       32'h0);
    tick();
    check("alu_ce_drop", {31'b0, o_ce}, 32'h0);
    check("alu_wb_hold", wb_data,       32'h1234);

    // Ack while IDLE must be ignored
    mem_ack = 1'b1; mem_rdata = 32'h9999;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_ce",  {31'b0, o_ce},    32'h0);
    check("idle_ack_req", {31'b0, mem_req}, 32'h0);

    // 2: LW at 0x43, ack 3 cycles after req goes high
    drive(1'b1, 6'h23, 32'h0000_0043, 32'h0, 5'd3, 1'b1);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    check("lw_req",   {31'b0, mem_req}, 32'h1);
    check("lw_we",    {31'b0, mem_we},  32'h0);
    check("lw_addr",  mem_addr,         32'h40);
    check("lw_stall", {31'b0, stall},   32'h1);
    check("lw_no_ce", {31'b0, o_ce},    32'h0);
    tick();
    check("lw_wait1_req", {31'b0, mem_req}, 32'h1);
    tick();
    check("lw_wait2_req",   {31'b0, mem_req}, 32'h1);
    check("lw_wait2_stall", {31'b0, stall},   32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("lw_done_ce",    {31'b0, o_ce},        32'h1);
    check("lw_done_wb",    wb_data,              32'hDEAD_BEEF);
    check("lw_done_rw",    {31'b0, o_reg_write}, 32'h1);
    check("lw_done_rd",    {27'b0, o_rd_addr},   32'd3);
    check("lw_done_req",   {31'b0, mem_req},     32'h0);
    check("lw_done_stall", {31'b0, stall},       32'h0);
    tick();
    check("lw_ce_drop", {31'b0, o_ce}, 32'h0);

    // 3: SW 0x55 to 0x80, ack on the first req cycle
    drive(1'b1, 6'h2B, 32'h80, 32'h55, 5'd7, 1'b1);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    check("sw_req",   {31'b0, mem_req}, 32'h1);
    check("sw_we",    {31'b0, mem_we},  32'h1);
    check("sw_addr",  mem_addr,         32'h80);
    check("sw_wdata", mem_wdata,        32'h55);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    check("sw_done_ce",  {31'b0, o_ce},        32'h1);
    check("sw_done_rw",  {31'b0, o_reg_write}, 32'h0);
    check("sw_done_wb",  wb_data,              32'h0);
    check("sw_done_req", {31'b0, mem_req},     32'h0);
    tick();

    // 4: LW followed immediately by an ALU op held by stall
    drive(1'b1, 6'h23, 32'h100, 32'h0, 5'd4, 1'b1);
    tick();
    drive(1'b1, 6'h00, 32'h77, 32'h0, 5'd2, 1'b1);
    check("b2b_stall", {31'b0, stall}, 32'h1);
    tick();
    check("b2b_held_ce", {31'b0, o_ce}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 1'b0;
    check("b2b_lw_ce", {31'b0, o_ce},      32'h1);
    check("b2b_lw_wb", wb_data,            32'hCAFE_0001);
    check("b2b_lw_rd", {27'b0, o_rd_addr}, 32'd4);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    check("b2b_alu_ce", {31'b0, o_ce},      32'h1);
    check("b2b_alu_wb", wb_data,            32'h77);
    check("b2b_alu_rd", {27'b0, o_rd_addr}, 32'd2);
    tick();
    check("b2b_no_dup", {31'b0, o_ce}, 32'h0);

    // 5: async reset mid-BUSY
    drive(1'b1, 6'h23, 32'h200, 32'h0, 5'd6, 1'b1);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    check("rst_mid_req_before", {31'b0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req",   {31'b0, mem_req}, 32'h0);
    check("rst_mid_stall", {31'b0, stall},   32'h0);
    check("rst_mid_ce",    {31'b0, o_ce},    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    check("rst_late_ack_ce", {31'b0, o_ce}, 32'h0);
    check("rst_late_ack_wb", wb_data,       32'h0);
    drive(1'b1, 6'h00, 32'h1234, 32'h0, 5'd9, 1'b1);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    check("post_rst_ce", {31'b0, o_ce},        32'h1);
    check("post_rst_wb", wb_data,              32'h1234);
    check("post_rst_rd", {27'b0, o_rd_addr},   32'd9);
    check("post_rst_rw", {31'b0, o_reg_write}, 32'h1);
    tick();

`ifdef MS_TIMEOUT_EN
    // 6a: no ack -> req high for 16 cycles, then error result
    drive(1'b1, 6'h23, 32'h300, 32'h0, 5'd8, 1'b1);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      check("to_req_held", {31'b0, mem_req}, 32'h1);
      tick();
    end
    check("to_req_16", {31'b0, mem_req}, 32'h1);
    tick();
    check("to_req_drop", {31'b0, mem_req},     32'h0);
    check("to_ce",       {31'b0, o_ce},        32'h1);
    check("to_err",      {31'b0, mem_err},     32'h1);
    check("to_rw",       {31'b0, o_reg_write}, 32'h0);
    tick();
    check("to_err_drop", {31'b0, mem_err}, 32'h0);
    check("to_ce_drop",  {31'b0, o_ce},    32'h0);

    // 6b: ack on the 16th req cycle wins over expiry
    drive(1'b1, 6'h23, 32'h304, 32'h0, 5'd8, 1'b1);
    tick();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("to_ack_req_16", {31'b0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hABCD_0016;
    tick();
    mem_ack = 1'b0;
    check("to_ack_ce",  {31'b0, o_ce},        32'h1);
    check("to_ack_err", {31'b0, mem_err},     32'h0);
    check("to_ack_wb",  wb_data,              32'hABCD_0016);
    check("to_ack_rw",  {31'b0, o_reg_write}, 32'h1);
    tick();
`else
    check("err_tied_low", {31'b0, mem_err}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
